// File: rtl/conv_pkg.sv
// Shared dimensions and bit-index helpers for the 5x5 image / 3x3 kernel convolution.
package conv_pkg;
  localparam int IMG_DIM = 5;
  localparam int K_DIM   = 3;
  localparam int OUT_DIM = 3;
  localparam int PIX_W   = 4;
  localparam int ACC_W   = 12;
  localparam int PROD_W  = 2 * PIX_W;
  localparam int NTAP    = K_DIM * K_DIM;
  localparam int NWIN    = OUT_DIM * OUT_DIM;

  // MSB position of each packed element; all buses are row-major, element 0 in the top bits
  function automatic int pix_hi(input int r, input int c);
    return IMG_DIM * IMG_DIM * PIX_W - 1 - PIX_W * (IMG_DIM * r + c);
  endfunction

  function automatic int wgt_hi(input int i, input int j);
    return NTAP * PIX_W - 1 - PIX_W * (K_DIM * i + j);
  endfunction

  function automatic int res_hi(input int r, input int c);
    return NWIN * ACC_W - 1 - ACC_W * (OUT_DIM * r + c);
  endfunction
endpackage

// File: rtl/add_tree9.sv
// Nine-input unsigned adder: 8-bit products summed through a balanced, widening tree.
module add_tree9
  import conv_pkg::*;
(
  input  logic [71:0] prods,
  output logic [11:0] sum
);
  logic [8:0]  l1 [4];
  logic [9:0]  l2 [2];
  logic [10:0] l3;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      l1[k] = {1'b0, prods[71 - 2*PROD_W*k -: PROD_W]} + {1'b0, prods[63 - 2*PROD_W*k -: PROD_W]};
    end
    for (int k = 0; k < 2; k++) begin
      l2[k] = {1'b0, l1[2*k]} + {1'b0, l1[2*k+1]};
    end
    l3 = {1'b0, l2[0]} + {1'b0, l2[1]};
    // the ninth product joins at the last level to keep the tree depth at four
    sum = {1'b0, l3} + {4'b0, prods[7:0]};
  end
endmodule

// File: rtl/top.sv
// 3x3 valid convolution of a 5x5 image: registered products, then registered window sums.
module top
  import conv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [99:0]  image,
  input  logic [35:0]  filter,
  output logic [107:0] ans,
  output logic [107:0] ans_
);
  logic [7:0]  prod_nxt [9][9];
  logic [7:0]  prod_q   [9][9];
  logic [11:0] sums     [9];

  for (genvar w = 0; w < NWIN; w++) begin : g_win
    logic [71:0] taps;
    for (genvar t = 0; t < NTAP; t++) begin : g_tap
      // window w anchors at (w/3, w%3); tap t offsets by (t/3, t%3)
      assign prod_nxt[w][t] =
        {4'b0, image[pix_hi(w/OUT_DIM + t/K_DIM, w%OUT_DIM + t%K_DIM) -: PIX_W]} *
        {4'b0, filter[wgt_hi(t/K_DIM, t%K_DIM) -: PIX_W]};
      assign taps[71 - PROD_W*t -: PROD_W] = prod_q[w][t];
    end
    add_tree9 u_tree (
      .prods (taps),
      .sum   (sums[w])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '{default: '0};
      ans    <= '0;
      ans_   <= '0;
    end else begin
      prod_q <= prod_nxt;
      for (int w = 0; w < NWIN; w++) begin
        ans[107 - ACC_W*w -: ACC_W] <= sums[w];
      end
      ans_ <= ans;
    end
  end
endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: reset, vector table, hand sequences and a randomized stream.
module tb_top;
  logic         clk = 1'b0;
  logic         reset;
  logic [99:0]  image;
  logic [35:0]  filter;
  logic [107:0] ans;
  logic [107:0] ans_;

  top dut (
    .clk    (clk),
    .reset  (reset),
    .image  (image),
    .filter (filter),
    .ans    (ans),
    .ans_   (ans_)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference pipeline: what the product stage, ans and ans_ should hold
  logic [107:0] m_stage = '0;
  logic [107:0] m_ans   = '0;
  logic [107:0] m_ans_  = '0;

  typedef struct {
    logic [99:0]  im;
    logic [35:0]  f;
    logic [107:0] exp;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [107:0] conv(input logic [99:0] img, input logic [35:0] f);
    logic [107:0] res;
    int s;
    res = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += int'(img[99 - 4*(5*(r+i) + c + j) -: 4]) * int'(f[35 - 4*(3*i + j) -: 4]);
        res[107 - 12*(3*r + c) -: 12] = s[11:0];
      end
    end
    return res;
  endfunction

  function automatic logic [99:0] rand_img();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[99:0];
  endfunction

  function automatic logic [35:0] rand_flt();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[35:0];
  endfunction

  // one clock: inputs glitch to garbage before settling, then the edge, then sample 1ns later
  task automatic cycle(input logic r, input logic [99:0] im, input logic [35:0] f);
    image  = rand_img();
    filter = rand_flt();
    #2;
    reset  = r;
    image  = im;
    filter = f;
    @(posedge clk);
    m_ans_  = r ? '0 : m_ans;
    m_ans   = r ? '0 : m_stage;
    m_stage = r ? '0 : conv(im, f);
    #1;
  endtask

  task automatic chk(input string name, input logic [107:0] act, input logic [107:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [99:0]  im;
    logic [107:0] prev_exp;

    tbl[0].im  = 100'h2111111111111111111111121;
    tbl[0].f   = 36'h111111111;
    tbl[0].exp = 108'h00A00900900900900900900A00A;
    tbl[1].im  = 100'h4222222222222222222222242;
    tbl[1].f   = 36'h111111111;
    tbl[1].exp = 108'h014012012012012012012014014;
    tbl[2].im  = {25{4'hF}};
    tbl[2].f   = {9{4'hF}};
    tbl[2].exp = {9{12'h7E9}};
    im = rand_img();
    tbl[3].im  = im;
    tbl[3].f   = 36'h000010000;
    tbl[3].exp = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        tbl[3].exp[107 - 12*(3*r + c) -: 12] = {8'b0, im[99 - 4*(5*(r+1) + c + 1) -: 4]};
    tbl[4].im  = rand_img();
    tbl[4].f   = rand_flt();
    tbl[4].exp = conv(tbl[4].im, tbl[4].f);

    reset  = 1'b1;
    image  = '0;
    filter = '0;
    @(posedge clk);
    #1;

    // reset held with arbitrary inputs
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, rand_img(), rand_flt());
      chk("reset_ans", ans, 108'h0);
      chk("reset_ans_", ans_, 108'h0);
    end

    // table: each vector held three cycles; first vector also covers release-from-reset latency
    prev_exp = '0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, tbl[k].im, tbl[k].f);
      chk("tbl_ans_old", ans, prev_exp);
      cycle(1'b0, tbl[k].im, tbl[k].f);
      chk("tbl_ans", ans, tbl[k].exp);
      chk("tbl_ans_prev", ans_, prev_exp);
      cycle(1'b0, tbl[k].im, tbl[k].f);
      chk("tbl_ans_delayed", ans_, tbl[k].exp);
      prev_exp = tbl[k].exp;
    end

    // one-cycle reset mid-stream flushes every stage
    for (int k = 0; k < 3; k++) cycle(1'b0, rand_img(), rand_flt());
    cycle(1'b1, {25{4'hF}}, {9{4'hF}});
    chk("midrst_ans", ans, 108'h0);
    chk("midrst_ans_", ans_, 108'h0);
    cycle(1'b0, tbl[2].im, tbl[2].f);
    chk("midrst_flushed", ans, 108'h0);
    chk("midrst_flushed_", ans_, 108'h0);
    cycle(1'b0, tbl[0].im, tbl[0].f);
    chk("midrst_resume", ans, tbl[2].exp);
    chk("midrst_resume_", ans_, 108'h0);
    cycle(1'b0, rand_img(), rand_flt());
    chk("midrst_resume2", ans, tbl[0].exp);
    chk("midrst_resume2_", ans_, tbl[2].exp);

    // randomized stream with occasional resets
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 19) == 0), rand_img(), rand_flt());
      chk("rand_ans", ans, m_ans);
      chk("rand_ans_", ans_, m_ans_);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 image  input  100  5x5 image of unsigned 4-bit pixels, row-major, MSB-first; pixel(r,c) at image[99-4*(5r+c) -: 4], so pixel(0,0)=image[99:96].
REQ-005 filter  input  36  3x3 kernel of unsigned 4-bit weights, row-major, MSB-first; weight(i,j) at filter[35-4*(3i+j) -: 4].
REQ-006 ans  output  108  3x3 convolution result of unsigned 12-bit elements, row-major, MSB-first; result(r,c) at ans[107-12*(3r+c) -: 12].
REQ-007 ans_  output  108  ans delayed by one further clock (previous result), same packing.

Function
REQ-008 result(r,c) SHALL equal sum over i,j in 0..2 of pixel(r+i,c+j)*weight(i,j), for r,c in 0..2 (valid convolution, stride 1, no padding, no kernel flip).
REQ-009 All arithmetic SHALL be unsigned: 8-bit products, 12-bit zero-extended sum; the maximum of 9*15*15=2025 fits, so no overflow or saturation is possible.
REQ-010 Stage 1 SHALL register all 81 products (9 windows x 9 taps) on each clk edge.
REQ-011 Stage 2 SHALL register the 9 nine-input sums into ans on each clk edge.
REQ-012 ans SHALL reflect the image and filter sampled 2 rising edges earlier; ans_ SHALL equal the value ans held one cycle earlier (latency 3).
REQ-013 There SHALL be no handshake; every output SHALL update every cycle as a free-running pipeline.
REQ-014 Input changes between edges SHALL have no effect until the next sampling edge.

Reset
REQ-015 While reset=1 at a clk edge, all pipeline registers, ans and ans_ SHALL load 0.
REQ-016 After reset is deasserted, the first non-zero ans SHALL appear 2 edges later and ans_ 3 edges later.
REQ-017 Reset asserted mid-stream SHALL flush all stages to 0 at that edge; no partial result SHALL survive.

Structure
REQ-018 A shared package SHALL hold IMG_DIM=5, K_DIM=3, OUT_DIM=3, PIX_W=4, ACC_W=12, and the pixel/weight/result index functions.
REQ-019 One sub-module, add_tree9, SHALL be instantiated 9 times; it takes nine 8-bit products and produces a 12-bit sum through a balanced tree of widening adders.
REQ-020 The multiply stage and output registers SHALL live in top.

Verification
REQ-021 Reset held, any inputs -> ans=0 and ans_=0 every cycle.
REQ-022 filter=36'h111111111, image=100'h2111111111111111111111121 -> 2 edges after reset release, ans elements (row-major) = 10,9,9, 9,9,9, 9,10,10 (hex 00A,009,009,009,009,009,009,00A,00A); ans_ matches one cycle later.
REQ-023 Same filter, image shifted left 1 bit (4222...2242) -> ans = 20,18,18, 18,18,18, 18,20,20 two edges after the change; ans_ still shows the prior values for one cycle.
REQ-024 All pixels F, all weights F -> every element = 2025 (12'h7E9).
REQ-025 filter with only the centre weight=1, random image -> result(r,c)=pixel(r+1,c+1) after 2 edges.
REQ-026 Reset asserted for one cycle mid-stream -> ans=0 the next cycle, valid results resume 2 edges after release.
